// File: rtl/rvs.sv
// Reservation station: accepts dispatched instructions into free entries, wakes
// waiting operands from the CDB and issues ready entries through an output register.
module rvs #(
  parameter int TAG_W    = 4,
  parameter int DEPTH    = 4,
  parameter int TAG_BASE = 1,
  parameter int OPC_W    = 4,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_req,
  output logic              dec_rdy,
  output logic [TAG_W-1:0]  dec_tag,
  input  logic [OPC_W-1:0]  dec_opc,
  input  logic              dec_src1_vld,
  input  logic [TAG_W-1:0]  dec_src1_tag,
  input  logic [DATA_W-1:0] dec_src1_wdata,
  input  logic              dec_src2_vld,
  input  logic [TAG_W-1:0]  dec_src2_tag,
  input  logic [DATA_W-1:0] dec_src2_wdata,
  input  logic              cdb_vld,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              exu_req,
  input  logic              exu_rdy,
  output logic [OPC_W-1:0]  exu_opc,
  output logic [DATA_W-1:0] exu_src1,
  output logic [DATA_W-1:0] exu_src2,
  output logic [TAG_W-1:0]  exu_tag
);
  // Valid/ready: a transfer on either port happens on a rising edge where req and
  // rdy are both high; rdy never looks at req, and exu_* hold while exu_req & ~exu_rdy.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  s1_vld;
  logic [DEPTH-1:0]  s2_vld;
  logic [OPC_W-1:0]  opc_q   [DEPTH];
  logic [TAG_W-1:0]  s1_tag  [DEPTH];
  logic [TAG_W-1:0]  s2_tag  [DEPTH];
  logic [DATA_W-1:0] s1_data [DEPTH];
  logic [DATA_W-1:0] s2_data [DEPTH];

  logic [IDX_W-1:0]  free_idx;
  logic [TAG_W-1:0]  free_tag;
  logic [IDX_W-1:0]  sel_idx;
  logic [TAG_W-1:0]  sel_tag;
  logic              any_ready;
  logic              dispatch;
  logic              issue;
  logic              d1_hit;
  logic              d2_hit;

  // Downward scans leave the lowest qualifying index; the full-station default
  // of free_tag is the last entry's tag.
  always_comb begin
    free_idx  = IDX_W'(DEPTH - 1);
    free_tag  = TAG_W'(TAG_BASE + DEPTH - 1);
    sel_idx   = '0;
    sel_tag   = '0;
    any_ready = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx = IDX_W'(i);
        free_tag = TAG_W'(TAG_BASE + i);
      end
      if (busy[i] && s1_vld[i] && s2_vld[i]) begin
        sel_idx   = IDX_W'(i);
        sel_tag   = TAG_W'(TAG_BASE + i);
        any_ready = 1'b1;
      end
    end
  end

  assign dec_rdy  = ~&busy;
  assign dec_tag  = free_tag;
  assign dispatch = dec_req && dec_rdy;
  assign issue    = (!exu_req || exu_rdy) && any_ready;
  assign d1_hit   = !dec_src1_vld && cdb_vld && (dec_src1_tag == cdb_tag);
  assign d2_hit   = !dec_src2_vld && cdb_vld && (dec_src2_tag == cdb_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      s1_vld   <= '0;
      s2_vld   <= '0;
      exu_req  <= 1'b0;
      exu_opc  <= '0;
      exu_src1 <= '0;
      exu_src2 <= '0;
      exu_tag  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        opc_q[i]   <= '0;
        s1_tag[i]  <= '0;
        s2_tag[i]  <= '0;
        s1_data[i] <= '0;
        s2_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && !s1_vld[i] && cdb_vld && (s1_tag[i] == cdb_tag)) begin
          s1_vld[i]  <= 1'b1;
          s1_data[i] <= cdb_data;
        end
        if (busy[i] && !s2_vld[i] && cdb_vld && (s2_tag[i] == cdb_tag)) begin
          s2_vld[i]  <= 1'b1;
          s2_data[i] <= cdb_data;
        end
      end
      // The dispatch target is free and the issue source is busy, so they never collide.
      if (dispatch) begin
        busy[free_idx]    <= 1'b1;
        opc_q[free_idx]   <= dec_opc;
        s1_tag[free_idx]  <= dec_src1_tag;
        s2_tag[free_idx]  <= dec_src2_tag;
        s1_vld[free_idx]  <= dec_src1_vld || d1_hit;
        s2_vld[free_idx]  <= dec_src2_vld || d2_hit;
        s1_data[free_idx] <= dec_src1_vld ? dec_src1_wdata : cdb_data;
        s2_data[free_idx] <= dec_src2_vld ? dec_src2_wdata : cdb_data;
      end
      if (issue) begin
        busy[sel_idx] <= 1'b0;
        exu_req       <= 1'b1;
        exu_opc       <= opc_q[sel_idx];
        exu_src1      <= s1_data[sel_idx];
        exu_src2      <= s2_data[sel_idx];
        exu_tag       <= sel_tag;
      end else if (exu_rdy) begin
        exu_req <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rvs.sv
// Directed bench for rvs: a vector table for dispatch/issue basics plus
// hand-written sequences for same-cycle capture, stalls, CDB misses and reset.
module tb_rvs;
  logic        clk = 1'b0;
  logic        rst;
  logic        dec_req;
  logic        dec_rdy;
  logic [3:0]  dec_tag;
  logic [3:0]  dec_opc;
  logic        dec_src1_vld, dec_src2_vld;
  logic [3:0]  dec_src1_tag, dec_src2_tag;
  logic [31:0] dec_src1_wdata, dec_src2_wdata;
  logic        cdb_vld;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        exu_req;
  logic        exu_rdy;
  logic [3:0]  exu_opc;
  logic [31:0] exu_src1, exu_src2;
  logic [3:0]  exu_tag;

  int total = 0;
  int bad   = 0;

  rvs dut (
    .clk(clk), .rst(rst),
    .dec_req(dec_req), .dec_rdy(dec_rdy), .dec_tag(dec_tag), .dec_opc(dec_opc),
    .dec_src1_vld(dec_src1_vld), .dec_src1_tag(dec_src1_tag), .dec_src1_wdata(dec_src1_wdata),
    .dec_src2_vld(dec_src2_vld), .dec_src2_tag(dec_src2_tag), .dec_src2_wdata(dec_src2_wdata),
    .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .exu_req(exu_req), .exu_rdy(exu_rdy), .exu_opc(exu_opc),
    .exu_src1(exu_src1), .exu_src2(exu_src2), .exu_tag(exu_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        req;
    logic [3:0]  opc;
    logic        v1;
    logic [3:0]  t1;
    logic [31:0] d1;
    logic        v2;
    logic [3:0]  t2;
    logic [31:0] d2;
    logic        cv;
    logic [3:0]  ct;
    logic [31:0] cd;
    logic        xrdy;
    logic        e_rdy;
    logic [3:0]  e_tag;
    logic        e_req;
    logic [3:0]  e_opc;
    logic [31:0] e_s1;
    logic [31:0] e_s2;
    logic [3:0]  e_xtag;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b0; dec_req = 1'b0; dec_opc = '0;
    dec_src1_vld = 1'b0; dec_src1_tag = '0; dec_src1_wdata = '0;
    dec_src2_vld = 1'b0; dec_src2_tag = '0; dec_src2_wdata = '0;
    cdb_vld = 1'b0; cdb_tag = '0; cdb_data = '0; exu_rdy = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic disp(input logic [3:0] opc, input logic v1, input logic [3:0] t1,
                      input logic [31:0] d1, input logic v2, input logic [3:0] t2,
                      input logic [31:0] d2);
    dec_req = 1'b1; dec_opc = opc;
    dec_src1_vld = v1; dec_src1_tag = t1; dec_src1_wdata = d1;
    dec_src2_vld = v2; dec_src2_tag = t2; dec_src2_wdata = d2;
  endtask

  task automatic chk_exu(input string name, input logic [3:0] opc, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [3:0] tag);
    chk({name, "_req"}, 32'(exu_req), 32'd1);
    chk({name, "_opc"}, 32'(exu_opc), 32'(opc));
    chk({name, "_s1"}, exu_src1, s1);
    chk({name, "_s2"}, exu_src2, s2);
    chk({name, "_tag"}, 32'(exu_tag), 32'(tag));
  endtask

  task automatic apply_vec(input int n, input vec_t v);
    disp(v.opc, v.v1, v.t1, v.d1, v.v2, v.t2, v.d2);
    dec_req = v.req;
    cdb_vld = v.cv; cdb_tag = v.ct; cdb_data = v.cd; exu_rdy = v.xrdy;
    #3;
    chk($sformatf("vec%0d_dec_rdy", n), 32'(dec_rdy), 32'(v.e_rdy));
    chk($sformatf("vec%0d_dec_tag", n), 32'(dec_tag), 32'(v.e_tag));
    if (v.e_req) chk_exu($sformatf("vec%0d", n), v.e_opc, v.e_s1, v.e_s2, v.e_xtag);
    else chk($sformatf("vec%0d_exu_req", n), 32'(exu_req), 32'd0);
    next_cycle();
  endtask

  initial begin
    // req opc v1 t1 d1 v2 t2 d2 | cv ct cd | xrdy | e_rdy e_tag e_req e_opc e_s1 e_s2 e_xtag
    vecs[0]  = '{1, 4'd0, 1, 4'd0, 32'd5, 1, 4'd0, 32'd7,    0, 4'd0, 32'd0,      0, 1, 4'd1, 0, 4'd0, 32'd0, 32'd0, 4'd0};
    vecs[1]  = '{0, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0,    0, 4'd0, 32'd0,      0, 1, 4'd2, 0, 4'd0, 32'd0, 32'd0, 4'd0};
    vecs[2]  = '{0, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0,    0, 4'd0, 32'd0,      1, 1, 4'd1, 1, 4'd0, 32'd5, 32'd7, 4'd1};
    vecs[3]  = '{0, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0,    0, 4'd0, 32'd0,      0, 1, 4'd1, 0, 4'd0, 32'd0, 32'd0, 4'd0};
    vecs[4]  = '{1, 4'd1, 0, 4'd9, 32'd0, 1, 4'd0, 32'h10,   0, 4'd0, 32'd0,      0, 1, 4'd1, 0, 4'd0, 32'd0, 32'd0, 4'd0};
    vecs[5]  = '{1, 4'd2, 0, 4'd9, 32'd0, 1, 4'd0, 32'h20,   0, 4'd0, 32'd0,      0, 1, 4'd2, 0, 4'd0, 32'd0, 32'd0, 4'd0};
    vecs[6]  = '{1, 4'd3, 0, 4'd9, 32'd0, 1, 4'd0, 32'h30,   0, 4'd0, 32'd0,      0, 1, 4'd3, 0, 4'd0, 32'd0, 32'd0, 4'd0};
    vecs[7]  = '{1, 4'd4, 0, 4'd9, 32'd0, 1, 4'd0, 32'h40,   0, 4'd0, 32'd0,      0, 1, 4'd4, 0, 4'd0, 32'd0, 32'd0, 4'd0};
    vecs[8]  = '{1, 4'd5, 1, 4'd0, 32'h55, 1, 4'd0, 32'h66,  0, 4'd0, 32'd0,      0, 0, 4'd4, 0, 4'd0, 32'd0, 32'd0, 4'd0};
    vecs[9]  = '{0, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0,    1, 4'd9, 32'h1234,   1, 0, 4'd4, 0, 4'd0, 32'd0, 32'd0, 4'd0};
    vecs[10] = '{0, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0,    0, 4'd0, 32'd0,      1, 0, 4'd4, 0, 4'd0, 32'd0, 32'd0, 4'd0};
    vecs[11] = '{0, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0,    0, 4'd0, 32'd0,      1, 1, 4'd1, 1, 4'd1, 32'h1234, 32'h10, 4'd1};
    vecs[12] = '{0, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0,    0, 4'd0, 32'd0,      1, 1, 4'd1, 1, 4'd2, 32'h1234, 32'h20, 4'd2};
    vecs[13] = '{0, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0,    0, 4'd0, 32'd0,      1, 1, 4'd1, 1, 4'd3, 32'h1234, 32'h30, 4'd3};
    vecs[14] = '{0, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0,    0, 4'd0, 32'd0,      1, 1, 4'd1, 1, 4'd4, 32'h1234, 32'h40, 4'd4};
    vecs[15] = '{0, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0,    0, 4'd0, 32'd0,      1, 1, 4'd1, 0, 4'd0, 32'd0, 32'd0, 4'd0};

    idle();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    idle();
    #3;
    chk("rst_dec_rdy", 32'(dec_rdy), 32'd1);
    chk("rst_dec_tag", 32'(dec_tag), 32'd1);
    chk("rst_exu_req", 32'(exu_req), 32'd0);
    chk("rst_exu_opc", 32'(exu_opc), 32'd0);
    chk("rst_exu_src1", exu_src1, 32'd0);
    chk("rst_exu_src2", exu_src2, 32'd0);
    chk("rst_exu_tag", 32'(exu_tag), 32'd0);
    next_cycle();

    for (int i = 0; i < 16; i++) apply_vec(i, vecs[i]);

    // Same-cycle CDB capture during dispatch.
    disp(4'd6, 1, 4'd0, 32'h11, 0, 4'd6, 32'd0);
    cdb_vld = 1'b1; cdb_tag = 4'd6; cdb_data = 32'hAB; exu_rdy = 1'b1;
    #3; chk("cap_dec_tag", 32'(dec_tag), 32'd1); next_cycle();
    exu_rdy = 1'b1; #3; chk("cap_t1_req", 32'(exu_req), 32'd0); next_cycle();
    exu_rdy = 1'b1; #3; chk_exu("cap_t2", 4'd6, 32'h11, 32'hAB, 4'd1); next_cycle();
    exu_rdy = 1'b1; #3; chk("cap_t3_req", 32'(exu_req), 32'd0); next_cycle();

    // Five-cycle stall with further entries becoming ready behind the held output.
    disp(4'd7, 1, 4'd0, 32'hA1, 1, 4'd0, 32'hA2); #3; chk("st_tag_a", 32'(dec_tag), 32'd1); next_cycle();
    disp(4'd8, 1, 4'd0, 32'hB1, 1, 4'd0, 32'hB2); #3; chk("st_tag_b", 32'(dec_tag), 32'd2); next_cycle();
    disp(4'd9, 1, 4'd0, 32'hC1, 1, 4'd0, 32'hC2); #3;
    chk("st_tag_c", 32'(dec_tag), 32'd1);
    chk_exu("st_s2", 4'd7, 32'hA1, 32'hA2, 4'd1);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      #3;
      chk($sformatf("st_hold%0d_dec_tag", k), 32'(dec_tag), 32'd3);
      chk_exu($sformatf("st_hold%0d", k), 4'd7, 32'hA1, 32'hA2, 4'd1);
      next_cycle();
    end
    exu_rdy = 1'b1; #3; chk_exu("st_go", 4'd7, 32'hA1, 32'hA2, 4'd1); next_cycle();
    exu_rdy = 1'b1; #3; chk_exu("st_drain0", 4'd9, 32'hC1, 32'hC2, 4'd1); next_cycle();
    exu_rdy = 1'b1; #3; chk_exu("st_drain1", 4'd8, 32'hB1, 32'hB2, 4'd2); next_cycle();
    exu_rdy = 1'b1; #3; chk("st_empty_req", 32'(exu_req), 32'd0); next_cycle();

    // CDB with no waiting tag, then reset mid-operation.
    disp(4'd10, 1, 4'd0, 32'h21, 1, 4'd0, 32'h22); next_cycle();
    disp(4'd12, 0, 4'd5, 32'd0, 1, 4'd0, 32'h31); next_cycle();
    disp(4'd12, 0, 4'd5, 32'd0, 1, 4'd0, 32'h32); #3; chk_exu("rs_x", 4'd10, 32'h21, 32'h22, 4'd1); next_cycle();
    disp(4'd12, 0, 4'd5, 32'd0, 1, 4'd0, 32'h33); next_cycle();
    cdb_vld = 1'b1; cdb_tag = 4'd3; cdb_data = 32'hDEAD; #3;
    chk("miss_dec_tag", 32'(dec_tag), 32'd4);
    chk_exu("miss_hold", 4'd10, 32'h21, 32'h22, 4'd1);
    next_cycle();
    exu_rdy = 1'b1; #3; chk_exu("miss_accept", 4'd10, 32'h21, 32'h22, 4'd1); next_cycle();
    disp(4'd11, 1, 4'd0, 32'h41, 1, 4'd0, 32'h42); #3;
    chk("miss_no_wake_req", 32'(exu_req), 32'd0);
    chk("miss_dec_tag2", 32'(dec_tag), 32'd4);
    next_cycle();
    #3; chk("full_dec_rdy", 32'(dec_rdy), 32'd0); next_cycle();
    rst = 1'b1; #3;
    chk_exu("pre_rst", 4'd11, 32'h41, 32'h42, 4'd4);
    chk("pre_rst_dec_rdy", 32'(dec_rdy), 32'd1);
    next_cycle();
    cdb_vld = 1'b1; cdb_tag = 4'd5; cdb_data = 32'h77; exu_rdy = 1'b1; #3;
    chk("post_rst_req", 32'(exu_req), 32'd0);
    chk("post_rst_dec_rdy", 32'(dec_rdy), 32'd1);
    chk("post_rst_dec_tag", 32'(dec_tag), 32'd1);
    chk("post_rst_exu_tag", 32'(exu_tag), 32'd0);
    chk("post_rst_exu_src1", exu_src1, 32'd0);
    next_cycle();
    exu_rdy = 1'b1; next_cycle();
    exu_rdy = 1'b1; #3;
    chk("post_rst_dropped_req", 32'(exu_req), 32'd0);
    chk("post_rst_dropped_tag", 32'(dec_tag), 32'd1);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
